// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register rename tags.
// Each register holds an architectural value, a busy flag and the ROB tag of
// its youngest in-flight producer. The decoder renames destinations at issue,
// the ROB commits values in order, and a rollback drops all pending renames.
// Source queries are combinational from the current state.
// Optional build macro: COMMIT_BYPASS_EN forwards a same-cycle commit onto a
// matching source query so the consumer sees the value without waiting a cycle.
module reg_file_rename #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                issue_valid,
    input  logic [REG_ID_W-1:0] issue_rd,
    input  logic [ROB_ID_W-1:0] issue_rob_id,
    input  logic                commit_reg_valid,
    input  logic [REG_ID_W-1:0] commit_reg_rd,
    input  logic [DATA_W-1:0]   commit_reg_data,
    input  logic [ROB_ID_W-1:0] commit_reg_rob_id,
    input  logic [REG_ID_W-1:0] rs1_id,
    input  logic [REG_ID_W-1:0] rs2_id,
    output logic                rs1_busy,
    output logic [ROB_ID_W-1:0] rs1_rob_id,
    output logic [DATA_W-1:0]   rs1_val,
    output logic                rs2_busy,
    output logic [ROB_ID_W-1:0] rs2_rob_id,
    output logic [DATA_W-1:0]   rs2_val
);

    localparam int NREG = 1 << REG_ID_W;

    logic [DATA_W-1:0]   r_val  [NREG];
    logic                r_busy [NREG];
    logic [ROB_ID_W-1:0] r_tag  [NREG];

    // Issue is suppressed by rollback; both only act when rdy is high.
    logic w_issue_en;
    logic w_commit_en;
    logic w_flush_en;

    assign w_issue_en  = issue_valid && rdy && !rollback;
    assign w_commit_en = commit_reg_valid && rdy;
    assign w_flush_en  = rollback && rdy;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            // x0 never matches, so its flops stay at their reset value of zero.
            logic w_issue_hit;
            logic w_commit_hit;
            logic w_tag_match;

            assign w_issue_hit  = w_issue_en  && (issue_rd == REG_ID_W'(gi)) && (gi != 0);
            assign w_commit_hit = w_commit_en && (commit_reg_rd == REG_ID_W'(gi)) && (gi != 0);
            assign w_tag_match  = (r_tag[gi] == commit_reg_rob_id);

            // Commit writes the value, even during rollback.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val[gi] <= '0;
                end else if (w_commit_hit) begin
                    r_val[gi] <= commit_reg_data;
                end
            end

            // Rename state: rollback clears, issue beats a same-cycle commit,
            // and a commit only frees the register if it is the latest producer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_busy[gi] <= 1'b0;
                    r_tag[gi]  <= '0;
                end else if (w_flush_en) begin
                    r_busy[gi] <= 1'b0;
                    r_tag[gi]  <= '0;
                end else if (w_issue_hit) begin
                    r_busy[gi] <= 1'b1;
                    r_tag[gi]  <= issue_rob_id;
                end else if (w_commit_hit && w_tag_match) begin
                    r_busy[gi] <= 1'b0;
                    r_tag[gi]  <= '0;
                end
            end
        end
    endgenerate

    // Source-1 query: pre-edge state, optionally bypassed from the commit bus.
    always_comb begin
        rs1_busy   = 1'b0;
        rs1_rob_id = '0;
        rs1_val    = '0;
        if (!rst) begin
            rs1_busy   = r_busy[rs1_id];
            rs1_rob_id = r_busy[rs1_id] ? r_tag[rs1_id] : '0;
            rs1_val    = r_val[rs1_id];
`ifdef COMMIT_BYPASS_EN
            if (commit_reg_valid && (rs1_id == commit_reg_rd) && (rs1_id != '0)
                && (r_tag[rs1_id] == commit_reg_rob_id)) begin
                rs1_busy   = 1'b0;
                rs1_rob_id = '0;
                rs1_val    = commit_reg_data;
            end
`endif
        end
    end

    // Source-2 query: same behaviour as source 1.
    always_comb begin
        rs2_busy   = 1'b0;
        rs2_rob_id = '0;
        rs2_val    = '0;
        if (!rst) begin
            rs2_busy   = r_busy[rs2_id];
            rs2_rob_id = r_busy[rs2_id] ? r_tag[rs2_id] : '0;
            rs2_val    = r_val[rs2_id];
`ifdef COMMIT_BYPASS_EN
            if (commit_reg_valid && (rs2_id == commit_reg_rd) && (rs2_id != '0)
                && (r_tag[rs2_id] == commit_reg_rob_id)) begin
                rs2_busy   = 1'b0;
                rs2_rob_id = '0;
                rs2_val    = commit_reg_data;
            end
`endif
        end
    end

endmodule
